// File: rtl/sea_pkg.sv
// Shared types and primitive functions for the iterative SEA-style Feistel core.
// Functions work on a fixed maximum-width vector and take the word size/count as arguments.
package sea_pkg;

    localparam int HMAX = 256;

    typedef logic [HMAX-1:0] hvec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYFWD = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] SBOX [8] = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd3, 3'd1, 3'd2};

    function automatic logic get_bit(input hvec_t x, input int pos);
        hvec_t t;
        t = x >> pos;
        return t[0];
    endfunction

    // Bitsliced S-box: bit k of words 3g, 3g+1, 3g+2 forms one 3-bit input (3g is the LSB)
    function automatic hvec_t sbox_slice(input hvec_t x, input int b, input int nb);
        hvec_t      y;
        logic [2:0] idx;
        logic [2:0] o;
        y = '0;
        for (int g = 0; g < nb / 3; g++) begin
            for (int k = 0; k < b; k++) begin
                idx = {get_bit(x, (3*g+2)*b + k), get_bit(x, (3*g+1)*b + k), get_bit(x, 3*g*b + k)};
                o   = SBOX[idx];
                y   = y | (hvec_t'(o[0]) << (3*g*b + k))
                        | (hvec_t'(o[1]) << ((3*g+1)*b + k))
                        | (hvec_t'(o[2]) << ((3*g+2)*b + k));
            end
        end
        return y;
    endfunction

    function automatic hvec_t rot_bits(input hvec_t x, input int b, input int nb);
        hvec_t y;
        y = '0;
        for (int g = 0; g < nb / 3; g++) begin
            for (int k = 0; k < b; k++) begin
                y = y | (hvec_t'(get_bit(x, 3*g*b + (k + 1) % b)) << (3*g*b + k))
                      | (hvec_t'(get_bit(x, (3*g+1)*b + k)) << ((3*g+1)*b + k))
                      | (hvec_t'(get_bit(x, (3*g+2)*b + (k + b - 1) % b)) << ((3*g+2)*b + k));
            end
        end
        return y;
    endfunction

    function automatic hvec_t rot_words(input hvec_t x, input int b, input int nb);
        hvec_t y;
        y = '0;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < b; k++) begin
                y = y | (hvec_t'(get_bit(x, ((j + nb - 1) % nb)*b + k)) << (j*b + k));
            end
        end
        return y;
    endfunction

    function automatic hvec_t rot_words_inv(input hvec_t x, input int b, input int nb);
        hvec_t y;
        y = '0;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < b; k++) begin
                y = y | (hvec_t'(get_bit(x, ((j + 1) % nb)*b + k)) << (j*b + k));
            end
        end
        return y;
    endfunction

    // Per-word modular addition; each word is masked so carries never propagate across words
    function automatic hvec_t wadd(input hvec_t x, input hvec_t k, input int b, input int nb);
        hvec_t y;
        hvec_t mask;
        hvec_t a;
        hvec_t c;
        y    = '0;
        mask = (hvec_t'(1) << b) - hvec_t'(1);
        for (int j = 0; j < nb; j++) begin
            a = (x >> (j*b)) & mask;
            c = (k >> (j*b)) & mask;
            y = y | (((a + c) & mask) << (j*b));
        end
        return y;
    endfunction

endpackage

// File: rtl/sea_iter_core_if.sv
// Block/key input and result output handshake bundle for sea_iter_core.
interface sea_iter_core_if #(parameter int W = 96);
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] key_in;
    logic [W-1:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dout;
    logic         busy;

    modport master (
        output in_valid, mode, key_in, din, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, mode, key_in, din, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/sea_round_f.sv
// Combinational SEA round function f(x,k) = r(S(x + k)) on one half-block.
module sea_round_f
    import sea_pkg::*;
#(
    parameter int B  = 8,
    parameter int NB = 6
)
(
    input  logic [NB*B-1:0] x,
    input  logic [NB*B-1:0] k,
    output logic [NB*B-1:0] y
);
    localparam int H = NB * B;

    assign y = H'(rot_bits(sbox_slice(wadd(hvec_t'(x), hvec_t'(k), B, NB), B, NB), B, NB));

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA-style encrypt/decrypt core: one round per cycle, key schedule stepped
// forward or backward on the fly, decrypt first winds the key forward to the last round.
module sea_iter_core
    import sea_pkg::*;
#(
    parameter int B  = 8,
    parameter int NB = 6,
    parameter int NR = 92
)
(
    input  logic          clk,
    input  logic          rst,
    sea_iter_core_if.slave bus
);
    localparam int H  = NB * B;
    localparam int W  = 2 * H;
    localparam int CW = (NR > 1) ? $clog2(NR) : 1;

    state_t          state_r;
    state_t          state_n;
    logic [W-1:0]    data_r;
    logic [H-1:0]    kl_r;
    logic [H-1:0]    kr_r;
    logic [CW-1:0]   cnt_r;
    logic            dec_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic [W-1:0]    dout_r;

    logic [H-1:0]    l_s;
    logic [H-1:0]    r_s;
    logic            kbwd_s;
    logic [CW-1:0]   kcnt_s;
    logic [H-1:0]    kconst_s;
    logic [H-1:0]    fx_s;
    logic [H-1:0]    kx_s;
    logic [H-1:0]    fd_s;
    logic [H-1:0]    fk_s;
    logic [H-1:0]    kmix_s;
    logic [W-1:0]    round_s;
    logic            last_s;

    assign l_s    = data_r[W-1:H];
    assign r_s    = data_r[H-1:0];
    assign kbwd_s = (state_r == ROUND) && dec_r;
    assign fx_s   = dec_r ? l_s : r_s;
    assign kx_s   = kbwd_s ? kl_r : kr_r;

    // Stepping back from key i+1 to key i needs C(i), i.e. one below the current counter
    always_comb begin
        kcnt_s   = kbwd_s ? (cnt_r - CW'(1)) : cnt_r;
        kconst_s = {H{1'b0}};
        kconst_s[B-1:0] = B'(kcnt_s);
    end

    sea_round_f #(.B(B), .NB(NB)) u_data_f (.x(fx_s), .k(kr_r),     .y(fd_s));
    sea_round_f #(.B(B), .NB(NB)) u_key_f  (.x(kx_s), .k(kconst_s), .y(fk_s));

    assign kmix_s = (kbwd_s ? kr_r : kl_r) ^ H'(rot_words(hvec_t'(fk_s), B, NB));

    // Next data state for one encrypt or decrypt round
    always_comb begin
        if (dec_r) begin
            round_s = {H'(rot_words_inv(hvec_t'(r_s ^ fd_s), B, NB)), l_s};
            last_s  = (cnt_r == {CW{1'b0}});
        end else begin
            round_s = {r_s, H'(rot_words(hvec_t'(l_s), B, NB)) ^ fd_s};
            last_s  = (cnt_r == CW'(NR - 1));
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n = bus.mode ? KEYFWD : ROUND;
                end else begin
                    state_n = IDLE;
                end
            end
            KEYFWD: begin
                if (cnt_r == CW'(NR - 2)) begin
                    state_n = ROUND;
                end else begin
                    state_n = KEYFWD;
                end
            end
            ROUND: begin
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = ROUND;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Data, key and round-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {W{1'b0}};
            kl_r   <= {H{1'b0}};
            kr_r   <= {H{1'b0}};
            cnt_r  <= {CW{1'b0}};
            dec_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_r <= bus.din;
                        kl_r   <= bus.key_in[W-1:H];
                        kr_r   <= bus.key_in[H-1:0];
                        dec_r  <= bus.mode;
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                KEYFWD: begin
                    kl_r  <= kr_r;
                    kr_r  <= kmix_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                ROUND: begin
                    data_r <= round_s;
                    if (dec_r) begin
                        kl_r  <= kmix_s;
                        kr_r  <= kl_r;
                        cnt_r <= cnt_r - CW'(1);
                    end else begin
                        kl_r  <= kr_r;
                        kr_r  <= kmix_s;
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE:    cnt_r <= cnt_r;
                default: cnt_r <= {CW{1'b0}};
            endcase
        end
    end

    // Registered handshake/status outputs; dout captures the final round and then holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            dout_r      <= {W{1'b0}};
        end else begin
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
            busy_r      <= (state_n == KEYFWD) || (state_n == ROUND);
            if ((state_r == ROUND) && last_s) begin
                dout_r <= round_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.dout      = dout_r;

endmodule

// File: tb/tb_sea_iter_core.sv
// Randomised self-checking bench for sea_iter_core against a word-level SEA reference model.
module tb_sea_iter_core;
    typedef logic [191:0] mvec_t;

    localparam int SBX [8] = '{0, 5, 6, 7, 4, 3, 1, 2};
    localparam int CB  [3] = '{8, 2, 2};
    localparam int CNB [3] = '{6, 3, 3};
    localparam int CNR [3] = '{92, 4, 8};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sea_iter_core_if #(.W(96)) ifb ();
    sea_iter_core_if #(.W(12)) ifs ();
    sea_iter_core_if #(.W(12)) ifw ();

    sea_iter_core #(.B(8), .NB(6), .NR(92)) u_big   (.clk(clk), .rst(rst), .bus(ifb));
    sea_iter_core #(.B(2), .NB(3), .NR(4))  u_small (.clk(clk), .rst(rst), .bus(ifs));
    sea_iter_core #(.B(2), .NB(3), .NR(8))  u_wrap  (.clk(clk), .rst(rst), .bus(ifw));

    always #5 clk = ~clk;

    task automatic check(input string tag, input mvec_t got, input mvec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (word arrays, precomputed key list) ----------------
    function automatic int unsigned getw(input mvec_t v, input int j, input int b);
        mvec_t       t;
        int unsigned w;
        t = v >> (j*b);
        w = t[31:0];
        return w & ((32'd1 << b) - 32'd1);
    endfunction

    function automatic mvec_t m_f(input mvec_t x, input mvec_t k, input int b, input int nb);
        int unsigned t [16];
        int unsigned u [16];
        int unsigned m;
        int unsigned idx;
        int unsigned o;
        mvec_t       y;
        m = (32'd1 << b) - 32'd1;
        for (int j = 0; j < nb; j++) begin
            t[j] = (getw(x, j, b) + getw(k, j, b)) & m;
            u[j] = 0;
        end
        for (int g = 0; g < nb / 3; g++) begin
            for (int bt = 0; bt < b; bt++) begin
                idx = ((t[3*g] >> bt) & 1) | (((t[3*g+1] >> bt) & 1) << 1) | (((t[3*g+2] >> bt) & 1) << 2);
                o   = SBX[idx];
                u[3*g]   = u[3*g]   | ((o & 1) << bt);
                u[3*g+1] = u[3*g+1] | (((o >> 1) & 1) << bt);
                u[3*g+2] = u[3*g+2] | (((o >> 2) & 1) << bt);
            end
            u[3*g]   = ((u[3*g] >> 1) | (u[3*g] << (b - 1))) & m;
            u[3*g+2] = ((u[3*g+2] << 1) | (u[3*g+2] >> (b - 1))) & m;
        end
        y = '0;
        for (int j = 0; j < nb; j++) y = y | (mvec_t'(u[j]) << (j*b));
        return y;
    endfunction

    function automatic mvec_t m_rotw(input mvec_t x, input int b, input int nb, input bit inv);
        mvec_t y;
        int    dst;
        y = '0;
        for (int j = 0; j < nb; j++) begin
            dst = inv ? (j + nb - 1) % nb : (j + 1) % nb;
            y = y | (mvec_t'(getw(x, j, b)) << (dst*b));
        end
        return y;
    endfunction

    function automatic mvec_t sea_model(input mvec_t key, input mvec_t blk, input bit dec,
                                        input int b, input int nb, input int nr);
        int    h;
        mvec_t hm, kl, kr, l, r, t;
        mvec_t rk [$];
        h  = b * nb;
        hm = (mvec_t'(1) << h) - mvec_t'(1);
        kl = (key >> h) & hm;
        kr = key & hm;
        l  = (blk >> h) & hm;
        r  = blk & hm;
        for (int i = 0; i < nr; i++) begin
            rk.push_back(kr);
            t  = kl ^ m_rotw(m_f(kr, mvec_t'(i % (1 << b)), b, nb), b, nb, 1'b0);
            kl = kr;
            kr = t;
        end
        if (!dec) begin
            for (int i = 0; i < nr; i++) begin
                t = r;
                r = m_rotw(l, b, nb, 1'b0) ^ m_f(r, rk[i], b, nb);
                l = t;
            end
        end else begin
            for (int i = nr - 1; i >= 0; i--) begin
                t = l;
                l = m_rotw(r ^ m_f(l, rk[i], b, nb), b, nb, 1'b1);
                r = t;
            end
        end
        return (l << h) | r;
    endfunction

    function automatic mvec_t model_of(input int sel, input mvec_t key, input mvec_t blk, input bit dec);
        return sea_model(key, blk, dec, CB[sel], CNB[sel], CNR[sel]);
    endfunction

    function automatic mvec_t rand_vec(input int sel);
        mvec_t r;
        int    w;
        w = 2 * CB[sel] * CNB[sel];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r & ((mvec_t'(1) << w) - mvec_t'(1));
    endfunction

    // ---------------- per-instance access ----------------
    task automatic drive_in(input int sel, input bit v, input bit m, input mvec_t k, input mvec_t d);
        case (sel)
            0: begin ifb.in_valid = v; ifb.mode = m; ifb.key_in = k[95:0]; ifb.din = d[95:0]; end
            1: begin ifs.in_valid = v; ifs.mode = m; ifs.key_in = k[11:0]; ifs.din = d[11:0]; end
            default: begin ifw.in_valid = v; ifw.mode = m; ifw.key_in = k[11:0]; ifw.din = d[11:0]; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input bit v);
        case (sel)
            0: ifb.out_ready = v;
            1: ifs.out_ready = v;
            default: ifw.out_ready = v;
        endcase
    endtask

    function automatic bit get_ov(input int sel);
        case (sel)
            0: return ifb.out_valid;
            1: return ifs.out_valid;
            default: return ifw.out_valid;
        endcase
    endfunction

    function automatic bit get_ir(input int sel);
        case (sel)
            0: return ifb.in_ready;
            1: return ifs.in_ready;
            default: return ifw.in_ready;
        endcase
    endfunction

    function automatic bit get_busy(input int sel);
        case (sel)
            0: return ifb.busy;
            1: return ifs.busy;
            default: return ifw.busy;
        endcase
    endfunction

    function automatic mvec_t get_dout(input int sel);
        case (sel)
            0: return mvec_t'(ifb.dout);
            1: return mvec_t'(ifs.dout);
            default: return mvec_t'(ifw.dout);
        endcase
    endfunction

    // Called #1 after the accept edge; counts edges until out_valid, bounded
    task automatic wait_ov(input int sel, output mvec_t res, output int lat);
        int bad;
        lat = 0;
        bad = 0;
        while (!get_ov(sel) && lat < 400) begin
            if (get_ir(sel) || !get_busy(sel)) bad++;
            @(posedge clk); #1;
            lat++;
        end
        res = get_dout(sel);
        check("ready_low_busy_high", mvec_t'(bad), mvec_t'(0));
    endtask

    task automatic finish_op(input int sel);
        set_ordy(sel, 1'b1);
        @(posedge clk); #1;
        set_ordy(sel, 1'b0);
    endtask

    task automatic do_op(input int sel, input bit dec, input mvec_t key, input mvec_t blk,
                         output mvec_t res, output int lat);
        @(posedge clk); #1;
        check("accept_ready", mvec_t'(get_ir(sel)), mvec_t'(1));
        drive_in(sel, 1'b1, dec, key, blk);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, 1'b0, '0, '0);
        wait_ov(sel, res, lat);
        finish_op(sel);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mvec_t k, d, k2, d2, ct, res, hold;
        int    lat;
        for (int s = 0; s < 3; s++) begin
            drive_in(s, 1'b0, 1'b0, '0, '0);
            set_ordy(s, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  mvec_t'(ifb.in_ready),  mvec_t'(1));
        check("rst_out_valid", mvec_t'(ifb.out_valid), mvec_t'(0));
        check("rst_busy",      mvec_t'(ifb.busy),      mvec_t'(0));
        check("rst_dout",      mvec_t'(ifb.dout),      mvec_t'(0));
        @(negedge clk);
        rst = 1'b0;

        // Full-size zero vector and round trip
        do_op(0, 1'b0, '0, '0, ct, lat);
        check("enc0_lat", mvec_t'(lat), mvec_t'(92));
        check("enc0_dout", ct, model_of(0, '0, '0, 1'b0));
        do_op(0, 1'b1, '0, ct, res, lat);
        check("dec0_lat", mvec_t'(lat), mvec_t'(183));
        check("dec0_dout", res, mvec_t'(0));

        k = mvec_t'(96'h0123456789ABCDEF01234567);
        d = mvec_t'(96'hDEADBEEFCAFEBABE00112233);
        for (int n = 0; n < 3; n++) begin
            do_op(0, 1'b0, k, d, ct, lat);
            check("big_enc", ct, model_of(0, k, d, 1'b0));
            do_op(0, 1'b1, k, ct, res, lat);
            check("big_dec_lat", mvec_t'(lat), mvec_t'(183));
            check("big_roundtrip", res, d);
            k = rand_vec(0);
            d = rand_vec(0);
        end

        // Small configuration, random pairs
        for (int n = 0; n < 200; n++) begin
            k = rand_vec(1);
            d = rand_vec(1);
            do_op(1, 1'b0, k, d, ct, lat);
            check("small_enc_lat", mvec_t'(lat), mvec_t'(4));
            check("small_enc", ct, model_of(1, k, d, 1'b0));
            do_op(1, 1'b1, k, ct, res, lat);
            check("small_dec_lat", mvec_t'(lat), mvec_t'(7));
            check("small_roundtrip", res, d);
        end

        // Counter wider than the word: round constant wraps mod 4
        for (int n = 0; n < 50; n++) begin
            k = rand_vec(2);
            d = rand_vec(2);
            do_op(2, 1'b0, k, d, ct, lat);
            check("wrap_enc_lat", mvec_t'(lat), mvec_t'(8));
            check("wrap_enc", ct, model_of(2, k, d, 1'b0));
            do_op(2, 1'b1, k, ct, res, lat);
            check("wrap_dec_lat", mvec_t'(lat), mvec_t'(15));
            check("wrap_roundtrip", res, d);
        end

        // Backpressure in DONE with a competing request held on the input
        k  = rand_vec(1);
        d  = rand_vec(1);
        k2 = rand_vec(1);
        d2 = rand_vec(1);
        @(posedge clk); #1;
        drive_in(1, 1'b1, 1'b0, k, d);
        @(posedge clk); #1;
        drive_in(1, 1'b1, 1'b0, k2, d2);
        wait_ov(1, hold, lat);
        check("bp_lat", mvec_t'(lat), mvec_t'(4));
        check("bp_first", hold, model_of(1, k, d, 1'b0));
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("bp_dout_stable", mvec_t'(ifs.dout),      hold);
            check("bp_valid_held",  mvec_t'(ifs.out_valid), mvec_t'(1));
            check("bp_not_ready",   mvec_t'(ifs.in_ready),  mvec_t'(0));
        end
        finish_op(1);
        check("bp_bubble_valid", mvec_t'(ifs.out_valid), mvec_t'(0));
        check("bp_bubble_ready", mvec_t'(ifs.in_ready),  mvec_t'(1));
        check("bp_bubble_busy",  mvec_t'(ifs.busy),      mvec_t'(0));
        @(posedge clk); #1;
        check("bp_accept_busy",  mvec_t'(ifs.busy),      mvec_t'(1));
        drive_in(1, 1'b0, 1'b0, '0, '0);
        wait_ov(1, res, lat);
        check("bp_second_lat", mvec_t'(lat), mvec_t'(4));
        check("bp_second", res, model_of(1, k2, d2, 1'b0));
        finish_op(1);

        // Reset in the middle of a full-size encryption
        k = rand_vec(0);
        d = rand_vec(0);
        @(posedge clk); #1;
        drive_in(0, 1'b1, 1'b0, k, d);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 1'b0, '0, '0);
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", mvec_t'(ifb.out_valid), mvec_t'(0));
        check("mid_rst_in_ready",  mvec_t'(ifb.in_ready),  mvec_t'(1));
        check("mid_rst_busy",      mvec_t'(ifb.busy),      mvec_t'(0));
        check("mid_rst_dout",      mvec_t'(ifb.dout),      mvec_t'(0));
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 1'b0, k, d, ct, lat);
        check("post_rst_lat", mvec_t'(lat), mvec_t'(92));
        check("post_rst_enc", ct, model_of(0, k, d, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sea_iter_core.md
Name: sea_iter_core

Overview:
- Parametrised, iterative SEA-style Feistel block cipher core. It is the next generation of the team's fixed 48-bit-half SEA encrypt/decrypt pair.
- Generalises word size, words per half and round count.
- One shared round datapath serves both encryption and decryption, selected per block by a mode bit.
- An on-the-fly key schedule runs forward and backward.
- Valid/ready handshakes on input and output let it sit between a host-side input register and an output buffer in the tapeout wrapper.

Parameters:
- B, 8, word width in bits; must be ≥ 2.
- NB, 6, words per half-block; must be a multiple of 3. Half width H = NB*B; block width W = 2*H.
- NR, 92, number of rounds; must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block and key present.
- in_ready  out  1  core can accept a block.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with the input.
- key_in  in  W  key {KL,KR}; KL = key_in[W-1:H].
- din  in  W  block {L,R}; L = din[W-1:H].
- out_valid  out  1  dout holds a result.
- out_ready  in  1  consumer accepts the result.
- dout  out  W  result {L,R}.
- busy  out  1  high in KEYFWD or ROUND.

Behaviour:
- Word j of a half occupies bits [j*B+B-1 : j*B].
- Primitive functions:
  - S: bitsliced 3-bit S-box {0,5,6,7,4,3,1,2} applied per group (w3i, w3i+1, w3i+2). Bit k of w3i is the input LSB and bit k of w3i+2 is the input MSB.
  - r: within each group, w3i rotates right by 1 bit, w3i+1 is unchanged, w3i+2 rotates left by 1 bit.
  - R: word rotate, y[j+1] = x[j] and y[0] = x[NB-1]. Rinv is its inverse.
  - ⊞: per-word addition mod 2^B; carries do not cross words.
  - C(i): half with word 0 = i mod 2^B and all other words 0.
- Key schedule: (KL0,KR0) = key_in.
  - Forward step: KL(i+1) = KR(i); KR(i+1) = KL(i) ^ R(r(S(KR(i) ⊞ C(i)))).
  - Backward step: KR(i) = KL(i+1); KL(i) = KR(i+1) ^ R(r(S(KR(i) ⊞ C(i)))).
  - Round key K(i) = KR(i).
- Encrypt round i, for i = 0..NR-1: L' = R; R' = R(L) ^ r(S(R ⊞ K(i))).
- Decrypt round i, for i = NR-1..0: R' = L; L' = Rinv(R ^ r(S(L ⊞ K(i)))).
- FSM states: IDLE, KEYFWD, ROUND, DONE.
  - IDLE: in_ready = 1. On in_valid, latch din, key_in and mode.
    - Encrypt: go to ROUND with cnt = 0.
    - Decrypt: go to KEYFWD with cnt = 0.
  - KEYFWD: one forward key step per cycle for NR-1 cycles, ending with key = (KL(NR-1), KR(NR-1)). Then go to ROUND with cnt = NR-1.
  - ROUND: one round per cycle.
    - Encrypt: step the key forward afterwards and increment cnt.
    - Decrypt: step the key backward afterwards and decrement cnt.
    - After the last round (cnt = NR-1 for encrypt, cnt = 0 for decrypt), go to DONE.
  - DONE: out_valid = 1 and dout holds the state register. On out_ready, go to IDLE.
- Latency from accept edge to out_valid: encrypt NR cycles; decrypt 2*NR-1 cycles.
- in_ready is low in every state except IDLE. The core does not accept a new block in the same cycle as an output handshake; it takes one bubble cycle.
- dout is stable while out_valid = 1 and out_ready = 0. in_valid is ignored outside IDLE.
- The round counter is $clog2(NR) bits wide. C(i) uses i mod 2^B, so the counter wraps into the constant for NR > 2^B.
- Reset, asynchronous and valid at any time including mid-operation:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - dout = 0, key and data registers = 0, cnt = 0.
  - Any in-flight block is discarded.

Decomposition:
- Package sea_pkg holds:
  - the FSM state enum;
  - the S-box constant array;
  - functions sbox_slice, rot_bits (r), rot_words (R) and rot_words_inv (Rinv), sized by B and NB;
  - function wadd for per-word addition.
- One sub-module, sea_round_f, computes f(x,k) = r(S(x ⊞ k)) combinationally. It is instantiated twice: once for the data path, with its output routed through R or Rinv, and once for the key path.

Test Plan:
- Encrypt, B=8, NB=6, NR=92: key = 0, din = 0 → out_valid rises exactly 92 cycles after accept; dout matches the golden model sea_model; in_ready is low throughout.
- Round trip: feed the previous ciphertext with mode = 1 and the same key → out_valid after 183 cycles; dout = 96'h0. Repeat with key = 96'h0123456789ABCDEF01234567 and din = 96'hDEADBEEFCAFEBABE00112233.
- Small config B=2, NB=3, NR=4 over 200 random key/block pairs → decrypt(encrypt(x)) = x and encrypt matches sea_model on every pair.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → dout and out_valid stay constant; a new in_valid during DONE is not accepted; the first accept occurs the cycle after the out_ready handshake.
- Reset mid-run: assert rst at round 40 → out_valid = 0, in_ready = 1 and dout = 0 immediately; the next block completes with the correct result and latency.
- Wrap: B=2, NB=3, NR=8 → confirm C(i) uses i mod 4 against the model, with no X on the counter boundary.
